multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle RV32I opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath control strobes. It handshakes with instruction and data memory (req/ready) and guards both with a wait watchdog. It sits between the instruction register and the datapath muxes, ALU and register file, and raises a sticky trap on an illegal opcode or a memory timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a req may wait for ready; 0 disables the watchdog
ENABLE_MEM, 1, 1: LOAD/STORE legal; 0: LOAD/STORE decode as illegal
ENABLE_JUMP, 1, 1: JAL/JALR legal; 0: JAL/JALR decode as illegal

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instruction[6:0] from the instruction register, valid in DECODE
imem_ready  input  1  instruction memory has data this cycle
dmem_ready  input  1  data access completes this cycle
imem_req  output  1  instruction fetch request
ir_write  output  1  load instruction register
pc_write  output  1  unconditional PC update
pc_write_cond  output  1  PC update if the branch compare is true
pc_src  output  2  00 pc+4, 01 pc+imm, 10 alu result (jalr)
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
reg_write  output  1  register file write enable
imm_data  output  1  ALU operand B = immediate
opcode_alu  output  2  01 OP-IMM, 11 OP, 10 add, 00 branch compare
mem_to_reg  output  1  writeback selects load data
wb_pc  output  1  writeback selects pc+4 (jumps)
trap  output  1  sticky fault flag
trap_cause  output  2  00 none, 01 imem timeout, 10 illegal opcode, 11 dmem timeout
state_o  output  3  current state, for debug

Behaviour:
- Reset (rst_n low, async): state=IDLE, latched opcode op_q=0, watchdog=0, trap=0, trap_cause=00. All outputs 0, except opcode_alu=10 and state_o=IDLE encoding.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Outputs are Moore-decoded from state and op_q. Only ir_write and pc_write in FETCH also depend on imem_ready (Mealy).
- IDLE: goes to FETCH in the next cycle.
- FETCH: imem_req=1. When imem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE: op_q<=opcode. Legal means opcode[1:0]=11 and opcode[6:2] is one of 00100 OP-IMM, 01100 OP, 01101 LUI, 00101 AUIPC, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR (subject to the ENABLE_MEM and ENABLE_JUMP parameters). Legal goes to EXEC; otherwise TRAP with cause 10.
- EXEC:
  - OP-IMM: imm_data=1, opcode_alu=01.
  - OP: imm_data=0, opcode_alu=11.
  - LUI, AUIPC, LOAD, STORE: imm_data=1, opcode_alu=10.
  - BRANCH: imm_data=0, opcode_alu=00, pc_write_cond=1, pc_src=01, then FETCH.
  - JAL: pc_write=1, pc_src=01.
  - JALR: imm_data=1, opcode_alu=10, pc_write=1, pc_src=10.
  - LOAD and STORE go to MEM; all others except BRANCH go to WB.
- MEM: dmem_req=1; dmem_we=1 for STORE only. Signals hold until dmem_ready. On ready, LOAD goes to WB and STORE goes to FETCH.
- WB: reg_write=1 for exactly one cycle. mem_to_reg=1 for LOAD; wb_pc=1 for JAL/JALR. Then FETCH.
- Watchdog:
  - Counts cycles spent in FETCH or MEM with ready low. It clears on every state change.
  - When the count reaches TIMEOUT_CYCLES with ready still low, go to TRAP with cause 01 (FETCH) or 11 (MEM).
  - Ready arriving in the same cycle the count reaches the limit wins: no trap.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- TRAP: trap=1, all strobes 0, and the cause is held. The only exit is reset.
- Reset mid-operation (e.g. in MEM with dmem_req high) forces all outputs low asynchronously.
- reg_write, dmem_req and pc_write never assert in IDLE, DECODE or TRAP.

Decomposition:
- Shared package: the state enum, the opcode[6:2] constants, the opcode_alu encodings, the pc_src encodings and the trap_cause codes.
- One sub-module, control_watchdog: a parametrised saturating wait counter with clear, enable and expired ports.

Test Plan:
- ADDI sequence (opcode 0010011), imem_ready high in the first FETCH cycle -> states 1,2,3,5,1. reg_write=1 only in WB; opcode_alu=01 and imm_data=1 in EXEC.
- LW (0000011) with dmem_ready delayed 3 cycles -> dmem_req high for exactly 4 cycles, dmem_we=0. WB has mem_to_reg=1; the instruction takes 8 cycles total.
- SW (0100011) -> MEM with dmem_we=1, returns to FETCH, reg_write never asserted. BEQ (1100011) -> pc_write_cond=1 and pc_src=01 in EXEC, then FETCH.
- opcode 0000010 (low bits 10) -> DECODE goes to TRAP, trap_cause=10, trap stays high for 20 further cycles with imem_ready toggling.
- TIMEOUT_CYCLES=4, imem_ready held low -> trap_cause=01 after 4 FETCH wait cycles. Repeat with ready arriving on the 4th cycle -> no trap, goes to DECODE.
- rst_n pulsed low mid-MEM -> dmem_req drops in the same cycle, and the next instruction starts IDLE then FETCH. With ENABLE_MEM=0, LW -> trap_cause=10.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encoding, opcode[6:2] major-opcode constants, ALU operation selects,
// PC source selects, trap cause codes and the opcode legality check.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  // opcode[6:2] major opcodes
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  // opcode_alu encodings
  localparam logic [1:0] ALU_BRANCH = 2'b00;
  localparam logic [1:0] ALU_OP_IMM = 2'b01;
  localparam logic [1:0] ALU_ADD    = 2'b10;
  localparam logic [1:0] ALU_OP     = 2'b11;

  // pc_src encodings
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // trap_cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IMEM    = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // True when the full 7-bit opcode names an instruction this build executes.
  function automatic logic is_legal(input logic [6:0] opc,
                                    input logic       en_mem,
                                    input logic       en_jump);
    logic ok;
    ok = 1'b0;
    if (opc[1:0] == 2'b11) begin
      case (opc[6:2])
        OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_BRANCH: ok = 1'b1;
        OPC_LOAD, OPC_STORE:                                ok = en_mem;
        OPC_JAL, OPC_JALR:                                  ok = en_jump;
        default:                                            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_watchdog.sv
// Saturating wait counter guarding a memory handshake.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - zero the count (has priority over i_enable)
//   i_enable    - a wait cycle is in progress; count it
//   o_expired   - this wait cycle brings the count to LIMIT (LIMIT=0: never)
module control_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: registers are written with non-blocking assignments so every reader
  // in the same edge sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(LIMIT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry is flagged during the wait cycle whose edge brings the count to
  // LIMIT, so the caller can still let a same-cycle ready win.
  if (LIMIT == 0) begin : g_off
    assign o_expired = 1'b0;
  end else begin : g_on
    assign o_expired = i_enable && (r_count >= CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, handshakes with
// instruction and data memory, and raises a sticky trap on an illegal opcode
// or a memory wait timeout.
// Ports:
//   opcode, imem_ready, dmem_ready         - instruction bits and memory readies
//   imem_req, ir_write, pc_write(_cond)    - fetch and PC control
//   pc_src, dmem_req, dmem_we, reg_write   - datapath steering and enables
//   imm_data, opcode_alu, mem_to_reg, wb_pc
//   trap, trap_cause, state_o              - fault status and debug state
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ENABLE_MEM     = 1'b1,
  parameter bit          ENABLE_JUMP    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic       imm_data,
  output logic [1:0] opcode_alu,
  output logic       mem_to_reg,
  output logic       wb_pc,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  state_t     r_state;
  logic [4:0] r_op;
  logic [1:0] r_trap_cause;
  logic       w_wait;
  logic       w_expired;

  // A wait can only end by the state changing, so "not waiting" also covers
  // clearing the count on every state change.
  assign w_wait = ((r_state == S_FETCH) && !imem_ready) ||
                  ((r_state == S_MEM)   && !dmem_ready);

  control_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_wait),
    .i_enable (w_wait),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_DECODE;
          end else if (w_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_IMEM;
          end
        end
        S_DECODE: begin
          r_op <= opcode[6:2];
          if (is_legal(opcode, ENABLE_MEM, ENABLE_JUMP)) begin
            r_state <= S_EXEC;
          end else begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          case (r_op)
            OPC_LOAD, OPC_STORE: r_state <= S_MEM;
            OPC_BRANCH:          r_state <= S_FETCH;
            default:             r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= (r_op == OPC_LOAD) ? S_WB : S_FETCH;
          end else if (w_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_DMEM;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state and latched opcode; only
  // the FETCH write strobes look at imem_ready directly.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // can infer a latch.
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_PLUS4;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    imm_data      = 1'b0;
    opcode_alu    = ALU_ADD;
    mem_to_reg    = 1'b0;
    wb_pc         = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC: begin
        case (r_op)
          OPC_OP_IMM: begin
            imm_data   = 1'b1;
            opcode_alu = ALU_OP_IMM;
          end
          OPC_OP: opcode_alu = ALU_OP;
          OPC_BRANCH: begin
            opcode_alu    = ALU_BRANCH;
            pc_write_cond = 1'b1;
            pc_src        = PC_IMM;
          end
          OPC_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_IMM;
          end
          OPC_JALR: begin
            imm_data = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
          // LUI, AUIPC, LOAD, STORE: immediate add
          default: imm_data = 1'b1;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_op == OPC_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_op == OPC_LOAD);
        wb_pc      = (r_op == OPC_JAL) || (r_op == OPC_JALR);
      end
      default: ;
    endcase
  end

  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. An instruction-level
// model expands each instruction (opcode, fetch wait, data wait) into the
// per-cycle output trace it must produce; the trace is replayed against the
// DUT. Unit A uses default parameters; unit B uses TIMEOUT_CYCLES=4 with
// memory and jump instructions disabled.
module tb_multicycle_control;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       imm_data;
    logic [1:0] opcode_alu;
    logic       mem_to_reg;
    logic       wb_pc;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    logic       irdy;
    logic       drdy;
    logic [6:0] opc;
    obs_t       exp;
  } step_t;

  typedef enum {K_OPIMM, K_OP, K_LUI, K_AUIPC, K_LOAD, K_STORE,
                K_BRANCH, K_JAL, K_JALR, K_ILL} kind_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  wire [19:0] obs_a;
  wire [19:0] obs_b;
  obs_t       oa;
  obs_t       ob;
  int         n_total = 0;
  int         n_bad   = 0;
  step_t      q[$];

  assign oa = obs_a;
  assign ob = obs_b;

  always #5 clk = ~clk;

  multicycle_control dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(obs_a[19]), .ir_write(obs_a[18]), .pc_write(obs_a[17]),
    .pc_write_cond(obs_a[16]), .pc_src(obs_a[15:14]), .dmem_req(obs_a[13]),
    .dmem_we(obs_a[12]), .reg_write(obs_a[11]), .imm_data(obs_a[10]),
    .opcode_alu(obs_a[9:8]), .mem_to_reg(obs_a[7]), .wb_pc(obs_a[6]),
    .trap(obs_a[5]), .trap_cause(obs_a[4:3]), .state_o(obs_a[2:0])
  );

  multicycle_control #(.TIMEOUT_CYCLES(4), .ENABLE_MEM(1'b0), .ENABLE_JUMP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(obs_b[19]), .ir_write(obs_b[18]), .pc_write(obs_b[17]),
    .pc_write_cond(obs_b[16]), .pc_src(obs_b[15:14]), .dmem_req(obs_b[13]),
    .dmem_we(obs_b[12]), .reg_write(obs_b[11]), .imm_data(obs_b[10]),
    .opcode_alu(obs_b[9:8]), .mem_to_reg(obs_b[7]), .wb_pc(obs_b[6]),
    .trap(obs_b[5]), .trap_cause(obs_b[4:3]), .state_o(obs_b[2:0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  // Quiet outputs for a given state: everything low, ALU select at "add".
  function automatic obs_t base(input int st);
    obs_t o;
    o            = '0;
    o.opcode_alu = 2'b10;
    o.state      = 3'(st);
    return o;
  endfunction

  function automatic kind_t kind_of(input logic [6:0] opc, input bit en_mem, input bit en_jump);
    if (opc[1:0] != 2'b11) return K_ILL;
    case (opc[6:2])
      5'b00100: return K_OPIMM;
      5'b01100: return K_OP;
      5'b01101: return K_LUI;
      5'b00101: return K_AUIPC;
      5'b00000: return en_mem ? K_LOAD : K_ILL;
      5'b01000: return en_mem ? K_STORE : K_ILL;
      5'b11000: return K_BRANCH;
      5'b11011: return en_jump ? K_JAL : K_ILL;
      5'b11001: return en_jump ? K_JALR : K_ILL;
      default:  return K_ILL;
    endcase
  endfunction

  task automatic push(input obs_t e, input logic irdy, input logic drdy, input logic [6:0] opc);
    step_t s;
    s.exp  = e;
    s.irdy = irdy;
    s.drdy = drdy;
    s.opc  = opc;
    q.push_back(s);
  endtask

  task automatic push_trap(input logic [1:0] cause, input int n);
    obs_t e;
    e            = base(7);
    e.trap       = 1'b1;
    e.trap_cause = cause;
    for (int i = 0; i < n; i++) push(e, rb(), rb(), ro());
  endtask

  // Expand one instruction into its expected cycle trace. idly/ddly are the
  // number of cycles the ready is withheld; waits reaching limit end in TRAP.
  task automatic gen(input logic [6:0] opc, input int idly, input int ddly, input int limit,
                     input bit en_mem, input bit en_jump, input int trap_len);
    kind_t k;
    obs_t  e;
    bit    tmo;
    int    nw;
    k   = kind_of(opc, en_mem, en_jump);
    tmo = (limit != 0) && (idly >= limit);
    nw  = tmo ? limit : idly;
    e = base(1);
    e.imem_req = 1'b1;
    for (int i = 0; i < nw; i++) push(e, 1'b0, rb(), ro());
    if (tmo) begin
      push_trap(2'b01, trap_len);
      return;
    end
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    push(e, 1'b1, rb(), ro());
    push(base(2), rb(), rb(), opc);
    if (k == K_ILL) begin
      push_trap(2'b10, trap_len);
      return;
    end
    e = base(3);
    case (k)
      K_OPIMM:  begin e.imm_data = 1'b1; e.opcode_alu = 2'b01; end
      K_OP:     e.opcode_alu = 2'b11;
      K_BRANCH: begin e.opcode_alu = 2'b00; e.pc_write_cond = 1'b1; e.pc_src = 2'b01; end
      K_JAL:    begin e.pc_write = 1'b1; e.pc_src = 2'b01; end
      K_JALR:   begin e.imm_data = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default:  e.imm_data = 1'b1;
    endcase
    push(e, rb(), rb(), ro());
    if (k == K_BRANCH) return;
    if (k == K_LOAD || k == K_STORE) begin
      tmo = (limit != 0) && (ddly >= limit);
      nw  = tmo ? limit : ddly;
      e = base(4);
      e.dmem_req = 1'b1;
      e.dmem_we  = (k == K_STORE);
      for (int i = 0; i < nw; i++) push(e, rb(), 1'b0, ro());
      if (tmo) begin
        push_trap(2'b11, trap_len);
        return;
      end
      push(e, rb(), 1'b1, ro());
      if (k == K_STORE) return;
    end
    e = base(5);
    e.reg_write  = 1'b1;
    e.mem_to_reg = (k == K_LOAD);
    e.wb_pc      = (k == K_JAL) || (k == K_JALR);
    push(e, rb(), rb(), ro());
  endtask

  // Replay up to maxn queued cycles: drive after the edge, compare mid-cycle.
  task automatic run_q(input bit sel, input string name, input int maxn);
    step_t s;
    int    n;
    n = 0;
    while (q.size() > 0 && n < maxn) begin
      s          = q.pop_front();
      imem_ready = s.irdy;
      dmem_ready = s.drdy;
      opcode     = s.opc;
      @(negedge clk);
      check($sformatf("%s_cyc%0d", name, n), sel ? ob : oa, s.exp);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", oa, base(0));
    check("reset_b", ob, base(0));
    rst_n = 1'b1;
  endtask

  logic [6:0] legal_ops [9] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                                7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                7'b1100111};

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode     = '0;

    // Directed sequence on unit A: ADDI, LW (3 wait cycles), SW, BEQ.
    do_reset();
    push(base(0), rb(), rb(), ro());
    gen(7'b0010011, 0, 0, 16, 1, 1, 0);
    gen(7'b0000011, 0, 3, 16, 1, 1, 0);
    gen(7'b0100011, 1, 2, 16, 1, 1, 0);
    gen(7'b1100011, 2, 0, 16, 1, 1, 0);
    run_q(0, "dir", 1000);

    // Random legal instructions with random wait lengths below the limit.
    for (int i = 0; i < 40; i++) begin
      gen(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 4), $urandom_range(0, 5),
          16, 1, 1, 0);
    end
    run_q(0, "rnd", 100000);

    // Illegal opcode (low bits 10): sticky trap for 20 cycles.
    gen(7'b0000010, 0, 0, 16, 1, 1, 20);
    run_q(0, "ill", 1000);

    // Asynchronous reset while a load is waiting in MEM.
    do_reset();
    push(base(0), rb(), rb(), ro());
    gen(7'b0000011, 0, 10, 16, 1, 1, 0);
    run_q(0, "pre", 6);
    q.delete();
    #2;
    check("dmem_req_before_rst", 32'(oa.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", oa, base(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(base(0), rb(), rb(), ro());
    gen(7'b0010011, 0, 0, 16, 1, 1, 0);
    // Store whose data ready never arrives: trap after 16 waits.
    gen(7'b0100011, 0, 16, 16, 1, 1, 5);
    run_q(0, "post", 1000);

    // Unit B: fetch timeout after 4 wait cycles.
    do_reset();
    push(base(0), rb(), rb(), ro());
    gen(7'b0010011, 6, 0, 4, 0, 0, 5);
    run_q(1, "b_tmo", 1000);

    // Unit B: ready on the 4th fetch cycle wins; then LW is illegal.
    do_reset();
    push(base(0), rb(), rb(), ro());
    gen(7'b0010011, 3, 0, 4, 0, 0, 0);
    gen(7'b0110011, 2, 0, 4, 0, 0, 0);
    gen(7'b0000011, 0, 0, 4, 0, 0, 5);
    run_q(1, "b_rdy", 1000);

    // Unit B: JAL is illegal with jumps disabled.
    do_reset();
    push(base(0), rb(), rb(), ro());
    gen(7'b1100011, 1, 0, 4, 0, 0, 0);
    gen(7'b1101111, 0, 0, 4, 0, 0, 3);
    run_q(1, "b_jal", 1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
